// File: rtl/pc_pkg.sv
// Shared defaults and next-PC select encoding for the program-counter unit.
package pc_pkg;

    localparam int unsigned PC_WIDTH_DEF     = 32;
    localparam int unsigned PC_RESET_VEC_DEF = 0;
    localparam int unsigned PC_STEP_DEF      = 4;
    localparam int unsigned PC_RAS_DEPTH_DEF = 4;

    // Source of the next PC; declaration order is not the priority order.
    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_JUMP,
        SEL_CALL,
        SEL_RET
    } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry. A pop when empty leaves the stack unchanged. Both cases raise a
// one-cycle strobe.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH     = PC_WIDTH_DEF,
    parameter int unsigned RAS_DEPTH = PC_RAS_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [PW:0]   CNT_ONE = 1;
    localparam logic [PW:0]   CNT_MAX = RAS_DEPTH[PW:0];

    // ptr_q is the next free slot. The top entry sits one below it, modulo depth.
    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d, top_idx;
    logic [PW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign top_idx   = ptr_q - PTR_ONE;
    assign rdata     = mem_q[top_idx];
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CNT_MAX);
    // Pop wins if both arrive, so a same-cycle push is dropped.
    assign do_pop    = pop && !empty;
    assign do_push   = push && !pop;
    assign overflow  = do_push && full;
    assign underflow = pop && empty;

    // Pointer and occupancy next state. Occupancy saturates at depth on overwrite.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (do_pop) begin
            ptr_d = ptr_q - PTR_ONE;
            cnt_d = cnt_q - CNT_ONE;
        end else if (do_push) begin
            ptr_d = ptr_q + PTR_ONE;
            if (!full) cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage has no reset, because entries are never read while the count is zero.
    always_ff @(posedge clk) begin
        if (!reset && do_push) mem_q[ptr_q] <= wdata;
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with jump/call/return redirect, a return-address stack
// and a sticky stack-error flag.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH     = PC_WIDTH_DEF,
    parameter int unsigned RESET_VEC = PC_RESET_VEC_DEF,
    parameter int unsigned STEP      = PC_STEP_DEF,
    parameter int unsigned RAS_DEPTH = PC_RAS_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             jump_en,
    input  logic             call_en,
    input  logic             ret_en,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus_step,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    logic [WIDTH-1:0] pc_q, pc_d, ras_rdata;
    logic             ras_err_q;
    logic             ras_push, ras_pop, ras_ovf, ras_udf;
    pc_sel_e          sel;

    assign pc_out       = pc_q;
    assign pc_plus_step = pc_q + WIDTH'(STEP);
    assign ras_err      = ras_err_q;

    // Select the next-PC source: ret > call > jump > sequential.
    always_comb begin
        sel = SEL_SEQ;
        if (ret_en)       sel = SEL_RET;
        else if (call_en) sel = SEL_CALL;
        else if (jump_en) sel = SEL_JUMP;
    end

    // Next PC mux. A return on an empty stack falls through to sequential.
    always_comb begin
        pc_d = pc_plus_step;
        case (sel)
            SEL_RET:            pc_d = ras_empty ? pc_plus_step : ras_rdata;
            SEL_CALL, SEL_JUMP: pc_d = jump_target;
            default:            pc_d = pc_plus_step;
        endcase
    end

    // A stall must not move the stack, so the stack strobes are gated here.
    assign ras_push = !stall && (sel == SEL_CALL);
    assign ras_pop  = !stall && (sel == SEL_RET);

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .wdata     (pc_plus_step),
        .rdata     (ras_rdata),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (ras_ovf),
        .underflow (ras_udf)
    );

    // PC register and sticky error flag. Stall holds both, and the stack strobes are already gated.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= WIDTH'(RESET_VEC);
            ras_err_q <= 1'b0;
        end else if (!stall) begin
            pc_q      <= pc_d;
            ras_err_q <= ras_err_q | ras_ovf | ras_udf;
        end
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 32: PC and target width in bits.
REQ-002 Parameter RESET_VEC, default 0: PC value loaded by reset.
REQ-003 Parameter STEP, default 4: sequential increment in bytes.
REQ-004 Parameter RAS_DEPTH, default 4: return-address stack entries, a power of two, at least 2.
REQ-005 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 stall  input  1  hold all state this cycle.
REQ-008 jump_en  input  1  redirect PC to jump_target.
REQ-009 call_en  input  1  push pc_out+STEP to the stack, then redirect to jump_target.
REQ-010 ret_en  input  1  pop the stack top into PC.
REQ-011 jump_target  input  WIDTH  redirect address for jump/call.
REQ-012 pc_out  output  WIDTH  current PC (registered).
REQ-013 pc_plus_step  output  WIDTH  pc_out+STEP (combinational), modulo 2^WIDTH.
REQ-014 ras_empty / ras_full  output  1 each  stack occupancy 0 / RAS_DEPTH.
REQ-015 ras_err  output  1  sticky flag: overflow or underflow occurred since reset.

Function
REQ-016 Next-PC priority SHALL be: reset > stall > ret_en > call_en > jump_en > sequential.
REQ-017 Sequential: pc_out <= pc_out+STEP; the adder SHALL wrap modulo 2^WIDTH (0xFFFFFFFC+4 -> 0x0 at WIDTH=32).
REQ-018 Redirect latency SHALL be one cycle: target is visible on pc_out the cycle after the enable is sampled.
REQ-019 stall=1: pc_out, stack contents, count, pointer and ras_err SHALL all hold; other inputs are ignored.
REQ-020 jump_en (winning): pc_out <= jump_target; stack untouched.
REQ-021 call_en (winning): push pc_plus_step, pc_out <= jump_target, count+1.
REQ-022 call_en when ras_full: push SHALL overwrite the oldest entry (circular); count stays RAS_DEPTH; ras_err <= 1.
REQ-023 ret_en with stack non-empty: pc_out <= top entry, count-1.
REQ-024 ret_en when ras_empty: pc_out <= pc_plus_step, stack unchanged, ras_err <= 1.
REQ-025 ret_en and call_en together: ret wins (per REQ-016); no push occurs.
REQ-026 The stack top pointer SHALL wrap modulo RAS_DEPTH in both directions.
REQ-027 ras_empty and ras_full SHALL be derived from the registered count, never from the pointer alone.
REQ-028 jump_target SHALL be used unaligned as given; no alignment check is performed.

Reset
REQ-029 On reset: pc_out = RESET_VEC, count = 0, top pointer = 0, ras_err = 0, ras_empty = 1, ras_full = 0.
REQ-030 Reset asserted mid-operation (including during stall or call) SHALL take effect at that edge and discard the pending action.
REQ-031 Stack entry storage need not be reset; entries are never read while count=0.

Structure
REQ-032 Shared package pc_pkg SHALL hold the parameter defaults and the next-PC select enum {SEL_SEQ, SEL_JUMP, SEL_CALL, SEL_RET}.
REQ-033 The stack SHALL be the sub-module pc_ras: push, pop, wdata, rdata, empty, full, overflow and underflow strobes, parameters WIDTH and RAS_DEPTH.
REQ-034 pc_unit SHALL contain only the select logic, PC register, adder and sticky error flag.

Verification (WIDTH=32, STEP=4, RAS_DEPTH=4, RESET_VEC=0)
REQ-035 Reset, then 3 idle cycles -> pc_out 0x0, 0x4, 0x8, 0xC; ras_empty=1.
REQ-036 At pc 0x10: call_en, target 0x100 -> pc_out 0x100 next cycle; 2 idle cycles, then ret_en at 0x108 -> pc_out 0x14; ras_empty=1; ras_err=0.
REQ-037 Five nested calls (return addresses A1..A5), then four rets -> returns A5, A4, A3, A2 in order; ras_err=1 after the fifth call; a fifth ret underflows -> pc_plus_step.
REQ-038 stall=1 for 3 cycles with jump_en/call_en asserted -> pc_out, count and ras_err unchanged; jump applied only in the first cycle after stall drops.
REQ-039 ret_en with call_en in the same cycle, one entry 0x44 -> pc_out 0x44, count 0; jump_en with ret_en -> ret wins.
REQ-040 pc_out=0xFFFFFFFC, idle -> 0x00000000; reset during a call cycle -> pc_out 0x0, count 0, ras_err 0.
